// File: rtl/mem_wb_stage_buf_if.sv
// MEM->WB pipeline buffer bundle: upstream handshake/payload, flush, downstream
// handshake/payload and the hazard-forwarding view of the head entry.
interface mem_wb_stage_buf_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_wb;
   logic [DATA_W-1:0] in_alu;
   logic [DATA_W-1:0] in_rdata;
   logic [ADDR_W-1:0] in_waddr;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic              mem_to_reg;
   logic              reg_write;
   logic [CTRL_W-1:0] out_wb;
   logic [DATA_W-1:0] out_alu;
   logic [DATA_W-1:0] out_rdata;
   logic [ADDR_W-1:0] out_waddr;

   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_waddr;
   logic [DATA_W-1:0] fwd_data;
   logic [1:0]        occupancy;

   // Stage side
   modport slave (
      input  in_valid, in_wb, in_alu, in_rdata, in_waddr, flush, out_ready,
      output in_ready, out_valid, mem_to_reg, reg_write, out_wb, out_alu,
             out_rdata, out_waddr, fwd_valid, fwd_waddr, fwd_data, occupancy
   );

   // Environment side (upstream producer + downstream consumer)
   modport master (
      output in_valid, in_wb, in_alu, in_rdata, in_waddr, flush, out_ready,
      input  in_ready, out_valid, mem_to_reg, reg_write, out_wb, out_alu,
             out_rdata, out_waddr, fwd_valid, fwd_waddr, fwd_data, occupancy
   );
endinterface

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB stage buffer: 2-entry skid buffer (SKID=1) or single-entry stage
// (SKID=0) with flush, occupancy and a combinational forwarding view.
module mem_wb_stage_buf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned SKID   = 1
) (
   input  logic              clock,
   input  logic              resetn,
   mem_wb_stage_buf_if.slave bus
);

   localparam int unsigned PW = CTRL_W + 2 * DATA_W + ADDR_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   skid_q, skid_d;
   logic            in_ready_q, in_ready_d;

   logic [PW-1:0]     in_pay;
   logic              in_ready;
   logic              out_valid;
   logic              accept;
   logic              consume;
   logic [CTRL_W-1:0] head_wb;
   logic [DATA_W-1:0] head_alu;
   logic [DATA_W-1:0] head_rdata;
   logic [ADDR_W-1:0] head_waddr;

   assign in_pay = {bus.in_wb, bus.in_alu, bus.in_rdata, bus.in_waddr};
   assign {head_wb, head_alu, head_rdata, head_waddr} = head_q;

   assign out_valid = (state_q != EMPTY);

   // Skid variant uses a registered ready; single-entry variant passes ready through
   assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);

   assign accept  = bus.in_valid && in_ready && !bus.flush;
   assign consume = out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_d  = in_pay;
            end
         end
         ONE: begin
            if (accept && consume) begin
               head_d = in_pay;
            end else if (accept && (SKID != 0)) begin
               state_d = TWO;
               skid_d  = in_pay;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (consume) begin
               state_d = ONE;
               head_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush overrides any handshake; stale payload is left in place
      if (bus.flush) begin
         state_d = EMPTY;
      end
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_wb     = head_wb;
   assign bus.out_alu    = head_alu;
   assign bus.out_rdata  = head_rdata;
   assign bus.out_waddr  = head_waddr;
   assign bus.mem_to_reg = head_wb[0];
   assign bus.reg_write  = head_wb[1];

   assign bus.fwd_valid = out_valid && head_wb[1] && (head_waddr != '0);
   assign bus.fwd_waddr = head_waddr;
   assign bus.fwd_data  = head_wb[0] ? head_rdata : head_alu;

   always_comb begin
      bus.occupancy = 2'd0;
      unique case (state_q)
         EMPTY:   bus.occupancy = 2'd0;
         ONE:     bus.occupancy = 2'd1;
         TWO:     bus.occupancy = 2'd2;
         default: bus.occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Bench for mem_wb_stage_buf: SKID=0 and SKID=1 instances side by side, each
// compared every cycle against a queue-based FIFO reference model.
module tb_mem_wb_stage_buf;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;
   localparam int unsigned AW = 5;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  waddr;
   } pay_t;

   typedef struct packed {
      logic        ir;
      logic        ov;
      logic [1:0]  occ;
      pay_t        p;
      logic        m2r;
      logic        rw;
      logic        fv;
      logic [4:0]  fa;
      logic [31:0] fd;
   } obs_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mem_wb_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)) b0 ();
   mem_wb_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)) b1 ();

   mem_wb_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .SKID(0)) u_dut0 (
      .clock(clk), .resetn(rstn), .bus(b0));
   mem_wb_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .SKID(1)) u_dut1 (
      .clock(clk), .resetn(rstn), .bus(b1));

   int   checks   = 0;
   int   failures = 0;
   pay_t mq[2][$];   // reference contents, head at index 0
   pay_t src[2][$];  // upstream items waiting to be accepted
   bit   zh[2];      // head register known to hold the reset value
   logic oready[2];
   logic flush[2];
   logic vld[2];
   bit   chk_en;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic pay_t mk(logic [1:0] wb, logic [31:0] alu, logic [31:0] rd, logic [4:0] wa);
      pay_t p;
      p.wb = wb; p.alu = alu; p.rdata = rd; p.waddr = wa;
      return p;
   endfunction

   function automatic pay_t rand_pay();
      return mk(2'($urandom), $urandom, $urandom, 5'($urandom));
   endfunction

   function automatic bit exp_ready(int d);
      if (d == 1) return mq[1].size() < 2;
      return (mq[0].size() == 0) || (oready[0] === 1'b1);
   endfunction

   task automatic sample(int d, output obs_t o);
      if (d == 0) begin
         o.ir = b0.in_ready; o.ov = b0.out_valid; o.occ = b0.occupancy;
         o.p = mk(b0.out_wb, b0.out_alu, b0.out_rdata, b0.out_waddr);
         o.m2r = b0.mem_to_reg; o.rw = b0.reg_write;
         o.fv = b0.fwd_valid; o.fa = b0.fwd_waddr; o.fd = b0.fwd_data;
      end else begin
         o.ir = b1.in_ready; o.ov = b1.out_valid; o.occ = b1.occupancy;
         o.p = mk(b1.out_wb, b1.out_alu, b1.out_rdata, b1.out_waddr);
         o.m2r = b1.mem_to_reg; o.rw = b1.reg_write;
         o.fv = b1.fwd_valid; o.fa = b1.fwd_waddr; o.fd = b1.fwd_data;
      end
   endtask

   task automatic drive(int d, logic v, pay_t p);
      if (d == 0) begin
         b0.in_valid = v; b0.in_wb = p.wb; b0.in_alu = p.alu;
         b0.in_rdata = p.rdata; b0.in_waddr = p.waddr;
         b0.flush = flush[0]; b0.out_ready = oready[0];
      end else begin
         b1.in_valid = v; b1.in_wb = p.wb; b1.in_alu = p.alu;
         b1.in_rdata = p.rdata; b1.in_waddr = p.waddr;
         b1.flush = flush[1]; b1.out_ready = oready[1];
      end
   endtask

   task automatic check_dut(int d);
      obs_t  o;
      pay_t  h;
      string n;
      n = $sformatf("d%0d", d);
      sample(d, o);
      chk({n, ".in_ready"}, o.ir, exp_ready(d));
      chk({n, ".out_valid"}, o.ov, mq[d].size() != 0);
      chk({n, ".occupancy"}, o.occ, mq[d].size());
      if (mq[d].size() != 0) begin
         h = mq[d][0];
         chk({n, ".payload"}, o.p, h);
         chk({n, ".mem_to_reg"}, o.m2r, h.wb[0]);
         chk({n, ".reg_write"}, o.rw, h.wb[1]);
         chk({n, ".fwd_valid"}, o.fv, h.wb[1] && (h.waddr != 5'd0));
         chk({n, ".fwd_waddr"}, o.fa, h.waddr);
         chk({n, ".fwd_data"}, o.fd, h.wb[0] ? h.rdata : h.alu);
      end else begin
         chk({n, ".fwd_valid_empty"}, o.fv, 1'b0);
         if (zh[d]) chk({n, ".payload_reset"}, o.p, '0);
      end
   endtask

   // One clock: drive at posedge+1, check at negedge, advance model at posedge
   task automatic cycle();
      bit r, acc, con;
      for (int d = 0; d < 2; d++) begin
         vld[d] = (src[d].size() != 0);
         drive(d, vld[d], vld[d] ? src[d][0] : rand_pay());
      end
      @(negedge clk);
      if (chk_en) for (int d = 0; d < 2; d++) check_dut(d);
      for (int d = 0; d < 2; d++) begin
         r = exp_ready(d);
         if (!rstn) begin
            mq[d].delete();
            zh[d] = 1'b1;
         end else if (flush[d]) begin
            mq[d].delete();
         end else begin
            acc = vld[d] && r;
            con = (mq[d].size() != 0) && oready[d];
            if (con) void'(mq[d].pop_front());
            if (acc) begin
               mq[d].push_back(src[d].pop_front());
               zh[d] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_both(pay_t p);
      src[0].push_back(p);
      src[1].push_back(p);
   endtask

   pay_t y3;

   initial begin
      chk_en = 1'b0;
      rstn   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         oready[d] = 1'b1; flush[d] = 1'b0; zh[d] = 1'b1;
      end
      cycle();
      chk_en = 1'b1;
      cycle();
      rstn = 1'b1;

      // pass-through
      push_both(mk(2'b10, 32'h10, $urandom, 5'd1));
      push_both(mk(2'b10, 32'h20, $urandom, 5'd2));
      push_both(mk(2'b10, 32'h30, $urandom, 5'd3));
      repeat (5) cycle();

      // backpressure
      oready[0] = 1'b0; oready[1] = 1'b0;
      push_both(mk(2'b00, 32'h1, $urandom, 5'd4));
      push_both(mk(2'b00, 32'h2, $urandom, 5'd5));
      push_both(mk(2'b00, 32'h3, $urandom, 5'd6));
      repeat (4) cycle();
      chk("bp.d1_in_ready", b1.in_ready, 1'b0);
      chk("bp.d1_head", b1.out_alu, 32'h1);
      oready[0] = 1'b1; oready[1] = 1'b1;
      repeat (6) cycle();

      // forwarding
      push_both(mk(2'b11, 32'hBEEF, 32'hDEAD, 5'd7));
      push_both(mk(2'b10, 32'hBEEF, 32'hDEAD, 5'd7));
      push_both(mk(2'b11, 32'hBEEF, 32'hDEAD, 5'd0));
      cycle();
      chk("fwd.valid_mem", b1.fwd_valid, 1'b1);
      chk("fwd.data_mem", b1.fwd_data, 32'hDEAD);
      cycle();
      chk("fwd.data_alu", b1.fwd_data, 32'hBEEF);
      cycle();
      chk("fwd.valid_x0", b1.fwd_valid, 1'b0);
      repeat (2) cycle();

      // flush from TWO with a same-cycle input
      oready[0] = 1'b0; oready[1] = 1'b0;
      push_both(mk(2'b10, 32'hA1, $urandom, 5'd8));
      push_both(mk(2'b10, 32'hA2, $urandom, 5'd9));
      repeat (3) cycle();
      chk("flush.pre_occ", b1.occupancy, 2'd2);
      push_both(mk(2'b10, 32'hA3, $urandom, 5'd10));
      flush[0] = 1'b1; flush[1] = 1'b1;
      cycle();
      flush[0] = 1'b0; flush[1] = 1'b0;
      src[0].delete(); src[1].delete();
      chk("flush.occ", b1.occupancy, 2'd0);
      chk("flush.out_valid", b1.out_valid, 1'b0);
      chk("flush.in_ready", b1.in_ready, 1'b1);
      oready[0] = 1'b1; oready[1] = 1'b1;
      repeat (2) cycle();

      // reset from TWO while flushing
      oready[0] = 1'b0; oready[1] = 1'b0;
      push_both(mk(2'b11, 32'hB1, 32'hC1, 5'd11));
      push_both(mk(2'b11, 32'hB2, 32'hC2, 5'd12));
      repeat (3) cycle();
      chk("rst.pre_occ", b1.occupancy, 2'd2);
      y3 = mk(2'b01, 32'hB3, 32'hC3, 5'd13);
      push_both(y3);
      rstn = 1'b0; flush[0] = 1'b1; flush[1] = 1'b1;
      cycle();
      rstn = 1'b1; flush[0] = 1'b0; flush[1] = 1'b0;
      chk("rst.occ", b1.occupancy, 2'd0);
      chk("rst.out_valid", b1.out_valid, 1'b0);
      chk("rst.fwd_valid", b1.fwd_valid, 1'b0);
      chk("rst.in_ready", b1.in_ready, 1'b1);
      chk("rst.payload", {b1.out_wb, b1.out_alu, b1.out_rdata, b1.out_waddr}, '0);
      oready[0] = 1'b1; oready[1] = 1'b1;
      src[0].delete();
      src[0].push_back(y3);
      cycle();
      chk("rst.first_valid", b1.out_valid, 1'b1);
      chk("rst.first_alu", b1.out_alu, y3.alu);
      repeat (2) cycle();

      // single-entry stage under toggling out_ready
      for (int i = 0; i < 6; i++) src[0].push_back(rand_pay());
      for (int i = 0; i < 12; i++) begin
         oready[0] = (i % 3) != 1;
         cycle();
      end
      oready[0] = 1'b1;
      repeat (8) cycle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            if (src[d].size() < 2 && $urandom_range(3) != 0) src[d].push_back(rand_pay());
            oready[d] = $urandom_range(3) != 0;
            flush[d]  = $urandom_range(24) == 0;
         end
         rstn = $urandom_range(79) != 0;
         cycle();
      end
      rstn = 1'b1;
      for (int d = 0; d < 2; d++) begin
         oready[d] = 1'b1; flush[d] = 1'b0;
      end
      repeat (8) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage_buf.md
MEM_WB_STAGE_BUF -- requirements
Module: mem_wb_stage_buf

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the ALU result and memory read data.
REQ-002 The block SHALL have parameter CTRL_W, default 2, width of the WB control vector, with CTRL_W >= 2; bit 0 is mem_to_reg and bit 1 is reg_write.
REQ-003 The block SHALL have parameter ADDR_W, default 5, width of the write-back register address.
REQ-004 The block SHALL have parameter SKID, default 1: 1 gives a 2-entry skid buffer, 0 gives a single-entry stage.
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clock, in, 1, the single rising-edge clock.
REQ-006 The block SHALL have port resetn, in, 1, a synchronous active-low reset sampled on the rising clock edge.
REQ-007 The block SHALL have ports in_valid (in, 1) and in_ready (out, 1), the upstream handshake.
REQ-008 The block SHALL have input ports in_wb (CTRL_W), in_alu (DATA_W), in_rdata (DATA_W) and in_waddr (ADDR_W), the upstream payload.
REQ-009 The block SHALL have port flush, in, 1, which discards all held entries.
REQ-010 The block SHALL have ports out_valid (out, 1) and out_ready (in, 1), the downstream handshake.
REQ-011 The block SHALL have output ports mem_to_reg (1), reg_write (1), out_wb (CTRL_W), out_alu (DATA_W), out_rdata (DATA_W) and out_waddr (ADDR_W), the head-entry payload.
REQ-012 The block SHALL have output ports fwd_valid (1), fwd_waddr (ADDR_W) and fwd_data (DATA_W), the hazard-forwarding view of the head entry.
REQ-013 The block SHALL have port occupancy, out, 2, giving the number of held entries (0..2).

Function
REQ-014 Upstream acceptance SHALL occur on a rising edge with in_valid && in_ready && !flush; downstream consumption SHALL occur on a rising edge with out_valid && out_ready.
REQ-015 With SKID=1, the block SHALL have states EMPTY, ONE and TWO, and in_ready SHALL be a registered signal equal to (state != TWO).
REQ-016 EMPTY SHALL go to ONE on accept, with the payload loaded into the head register.
REQ-017 ONE SHALL go to TWO on accept without consume, with the payload loaded into the skid register.
REQ-018 ONE SHALL go to EMPTY on consume without accept.
REQ-019 ONE SHALL stay in ONE on simultaneous accept and consume, with the head register loaded with the new payload.
REQ-020 TWO SHALL go to ONE on consume, with the skid register moved into the head register; no accept is possible in TWO.
REQ-021 With SKID=0, in_ready SHALL equal !out_valid || out_ready combinationally, the depth SHALL be 1, and the states SHALL be EMPTY and ONE only.
REQ-022 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-023 The head payload outputs SHALL hold their value while out_valid && !out_ready, with ordering strictly FIFO.
REQ-024 mem_to_reg SHALL equal out_wb[0] and reg_write SHALL equal out_wb[1].
REQ-025 The latency from accept to out_valid SHALL be 1 cycle when the block is EMPTY.
REQ-026 The block SHALL sustain a throughput of 1 transfer per cycle when out_ready is held at 1.
REQ-027 fwd_valid SHALL equal out_valid && reg_write && (out_waddr != 0).
REQ-028 fwd_waddr SHALL equal out_waddr.
REQ-029 fwd_data SHALL equal out_rdata when mem_to_reg is 1 and out_alu otherwise, with no extra register stage.
REQ-030 flush SHALL take priority over accept and consume: the next state SHALL be EMPTY, a same-cycle input SHALL be dropped, and payload registers need not be cleared.
REQ-031 After a flush, in_ready SHALL be 1 on the next cycle.
REQ-032 occupancy SHALL be 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-033 Payload registers SHALL load only on their own load condition, with no X-propagation from an idle in_* bus.

Reset
REQ-034 While resetn is 0 at a rising edge, the next state SHALL be EMPTY, and out_valid, fwd_valid and occupancy SHALL be 0.
REQ-035 While resetn is 0 at a rising edge, in_ready SHALL be 1 when SKID=1.
REQ-036 While resetn is 0 at a rising edge, out_wb, out_alu, out_rdata and out_waddr SHALL be 0, and the skid register SHALL be 0.
REQ-037 Reset SHALL take priority over flush and over any handshake in the same cycle.
REQ-038 A reset asserted mid-operation with the state TWO SHALL discard both entries and give occupancy 0 on the next cycle.

Verification
REQ-039 The bench SHALL cover pass-through: out_ready=1, inputs alu=0x10, 0x20, 0x30 on consecutive cycles -> outputs 0x10, 0x20, 0x30 one cycle later each, with occupancy constant at 1.
REQ-040 The bench SHALL cover backpressure: out_ready=0 with three inputs offered, A=0x1, B=0x2, C=0x3 -> A and B accepted, in_ready=0 from the cycle after B, C held upstream; then with out_ready=1 -> outputs in order A, B, C.
REQ-041 The bench SHALL cover forwarding: wb=2'b11, rdata=0xDEAD, alu=0xBEEF, waddr=7 -> fwd_valid=1, fwd_data=0xDEAD; the same with wb=2'b10 -> fwd_data=0xBEEF; waddr=0 -> fwd_valid=0.
REQ-042 The bench SHALL cover flush: from state TWO, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and the flushed-cycle input does not appear.
REQ-043 The bench SHALL cover reset: resetn=0 for 1 cycle while in state TWO with flush=1 -> all outputs 0, in_ready=1; the first accept afterwards appears at the output after 1 cycle.
REQ-044 The bench SHALL cover SKID=0: out_ready toggling 1,0,1 under continuous input -> no entry lost or duplicated, and in_ready tracks out_ready while full.
